// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers for the bus arbiter slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Beats still owed after the NONSEQ beat; undefined-length bursts owe nothing.
    function automatic logic [3:0] burst_beats(input hburst_e hburst);
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   burst_beats = 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant and muxed-bus signals shared between the masters and the arbiter.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic                   hresp;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic [MW-1:0]          hmaster_d;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_burst_counter.sv
// Tracks beats still owed in the current fixed-length burst; burst_done allows handover.
module ahb_burst_counter
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    input  logic       hresp,
    output logic       burst_done
);

    logic [3:0] cnt;
    logic [3:0] cnt_next;

    // An ERROR response terminates the burst regardless of the transfer type.
    always_comb begin
        cnt_next = cnt;
        if (hresp) begin
            cnt_next = 4'd0;
        end else begin
            case (htrans_e'(htrans))
                HTRANS_IDLE:   cnt_next = 4'd0;
                HTRANS_BUSY:   cnt_next = cnt;
                HTRANS_NONSEQ: cnt_next = burst_beats(hburst_e'(hburst));
                HTRANS_SEQ:    cnt_next = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                default:       cnt_next = cnt;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt <= 4'd0;
        end else if (hready) begin
            cnt <= cnt_next;
        end
    end

    assign burst_done = (cnt_next == 4'd0);

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: burst-aware, lock-aware grant plus address/data ownership pipeline.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input logic             hclk,
    input logic             hresetn,
    ahb_bus_arbiter_if.slave bus
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] hgrant_q;
    logic [NUM_MASTERS-1:0] hgrant_next;
    logic [MW-1:0]          cur;
    logic [MW-1:0]          last_q;
    logic [MW-1:0]          winner;
    logic [MW-1:0]          hmaster_q;
    logic [MW-1:0]          hmaster_d_q;
    logic                   hmastlock_q;
    logic                   burst_done;
    logic                   found;
    logic                   rearb;
    logic                   grant_chg;

    ahb_burst_counter u_burst_counter (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .htrans     (bus.htrans),
        .hburst     (bus.hburst),
        .hready     (bus.hready),
        .hresp      (bus.hresp),
        .burst_done (burst_done)
    );

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) cur = MW'(i);
        end
    end

    // Search starts just past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        int j;
        j      = 0;
        found  = 1'b0;
        winner = cur;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = int'(last_q) + i;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && bus.hbusreq[MW'(j)]) begin
                found  = 1'b1;
                winner = MW'(j);
            end
        end
    end

    always_comb begin
        rearb       = burst_done && !(bus.hlock[cur] && bus.hbusreq[cur]);
        grant_chg   = rearb && found && (winner != cur);
        hgrant_next = hgrant_q;
        if (grant_chg) begin
            hgrant_next         = '0;
            hgrant_next[winner] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant_q    <= DEF_GNT;
            hmaster_q   <= DEF_IDX;
            hmaster_d_q <= DEF_IDX;
            hmastlock_q <= 1'b0;
            last_q      <= DEF_IDX;
        end else if (bus.hready) begin
            hmaster_d_q <= hmaster_q;
            hmaster_q   <= cur;
            hmastlock_q <= bus.hlock[cur];
            hgrant_q    <= hgrant_next;
            if (grant_chg) last_q <= winner;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmaster_d = hmaster_d_q;
    assign bus.hmastlock = hmastlock_q;

endmodule
